reg_pipe: RTL and testbench

Parametrised elastic pipeline register: the multi-stage, flow-controlled successor to the single-cycle data register. It carries DWIDTH-bit beats through STAGES register slices with valid/ready handshaking on both sides. It collapses bubbles, supports a synchronous flush and reports its occupancy. It sits between any two valid/ready blocks in the datapath and is driven in the testbench through the register interface's clock and reset generation.

---
 rtl/reg_pipe.sv | 92 +++++++++
 tb/tb_reg_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// reg_pipe: elastic multi-stage pipeline register with valid/ready on both
// sides, bubble collapse, synchronous flush and a registered occupancy count.
module reg_pipe #(
    parameter  int DWIDTH = 32,
    parameter  int STAGES = 3,
    localparam int CWIDTH = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CWIDTH-1:0] count
);

    logic [STAGES-1:0]             v_q, v_d;
    logic [STAGES-1:0][DWIDTH-1:0] d_q, d_d;
    logic [CWIDTH-1:0]             count_q, count_d;
    logic [STAGES:0]               rdy;
    logic                          in_xfer, out_xfer;

    // Ready chain, walked from the output side back to the input side:
    // a stage can take a beat if it is empty or the stage after it moves.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            rdy[STAGES-1-i] = ~v_q[STAGES-1-i] | rdy[STAGES-i];
        end
    end

    assign in_ready  = rdy[0] & ~flush & rst;
    assign out_valid = v_q[STAGES-1] & ~flush;
    assign out_data  = d_q[STAGES-1];
    assign count     = count_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Stage advance: each ready stage takes the previous stage's contents;
    // data is only overwritten by a valid beat, and flush empties everything.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (rdy[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = in_data;
            end
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    d_d[k] = d_q[k-1];
                end
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    // Occupancy: +1 per accepted beat, -1 per emitted beat, cleared on flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CWIDTH'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CWIDTH'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: scoreboard bench for reg_pipe (DWIDTH=32, STAGES=3).
module tb_reg_pipe;

    localparam int DW = 32;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    count;

    typedef struct {
        logic [DW-1:0] d;
        int            cyc;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    peak = 0;
    int    n_out = 0;
    bit    mon_en = 1'b0;
    bit    lat_chk = 1'b0;

    reg_pipe #(.DWIDTH(DW), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: sample between edges; record accepted beats, compare emitted ones.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else if (mon_en) begin
            beat_t b;
            check_eq("count", 32'(count), 32'(sb.size()));
            check_eq("in_ready", 32'(in_ready), 32'(!flush && (sb.size() < ST || out_ready)));
            if (sb.size() == 0) check_eq("out_valid_empty", 32'(out_valid), 32'(0));
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check_eq("spurious_out", 32'(out_valid), 32'(0));
                end else begin
                    b = sb.pop_front();
                    check_eq("out_data", out_data, b.d);
                    if (lat_chk) check_eq("latency", 32'(cyc - b.cyc), 32'(ST));
                end
            end
            if (in_valid && in_ready) begin
                b.d   = in_data;
                b.cyc = cyc;
                sb.push_back(b);
            end
            if (flush) sb.delete();
            if (sb.size() > peak) peak = sb.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] data);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("push_timeout", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            step();
            if (sb.size() == 0 && !out_valid) break;
        end
        check_eq("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int base;
        // Reset held with a beat offered at the input.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("rst_in_ready", 32'(in_ready), 32'(0));
        check_eq("rst_count", 32'(count), 32'(0));
        check_eq("rst_out_data", out_data, 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rel_in_ready", 32'(in_ready), 32'(1));
        check_eq("rel_out_valid", 32'(out_valid), 32'(0));
        check_eq("rel_count", 32'(count), 32'(0));
        step();
        mon_en = 1'b1;

        // Streaming with latency check.
        out_ready = 1'b1;
        lat_chk = 1'b1;
        peak = 0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
        end
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;
        check_eq("stream_peak", 32'(peak), 32'(ST));

        // Backpressure until full, then release.
        out_ready = 1'b0;
        base = n_out;
        push(32'hA);
        push(32'hB);
        push(32'hC);
        in_valid = 1'b1;
        in_data  = 32'hD;
        repeat (3) begin
            @(negedge clk);
            check_eq("full_in_ready", 32'(in_ready), 32'(0));
            check_eq("full_count", 32'(count), 32'(ST));
            check_eq("full_out_valid", 32'(out_valid), 32'(1));
            check_eq("full_out_data", out_data, 32'hA);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("full_accept_d", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
        drain();
        check_eq("bp_emitted", 32'(n_out - base), 32'(4));

        // Bubble collapse under stall.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h11;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_valid = 1'b1;
        in_data  = 32'h22;
        step();
        in_valid = 1'b0;
        step();
        check_eq("bubble_count", 32'(count), 32'(2));
        check_eq("bubble_valid", 32'(dut.v_q), 32'b110);
        check_eq("bubble_stage1", dut.d_q[1], 32'h22);
        check_eq("bubble_stage2", dut.d_q[2], 32'h11);
        out_ready = 1'b1;
        drain();

        // Flush while full with a beat offered.
        out_ready = 1'b0;
        push(32'h31);
        push(32'h32);
        push(32'h33);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h55;
        @(negedge clk);
        check_eq("flush_in_ready", 32'(in_ready), 32'(0));
        check_eq("flush_out_valid", 32'(out_valid), 32'(0));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_flush_count", 32'(count), 32'(0));
        check_eq("post_flush_valid", 32'(out_valid), 32'(0));
        out_ready = 1'b1;
        repeat (6) step();

        // Full pass-through at one beat per cycle.
        out_ready = 1'b0;
        push(32'h41);
        push(32'h42);
        push(32'h43);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            @(negedge clk);
            check_eq("pass_in_ready", 32'(in_ready), 32'(1));
            check_eq("pass_count", 32'(count), 32'(ST));
            step();
        end
        in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-stream discards all beats.
        out_ready = 1'b0;
        push(32'h71);
        push(32'h72);
        #3 rst = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("mid_rst_count", 32'(count), 32'(0));
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'(0));
        check_eq("mid_rst_out_data", out_data, 32'(0));
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (6) step();
        check_eq("mid_rst_no_out", 32'(out_valid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
